// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon Says sequencer and its colour LFSR.
package simon_pkg;

   localparam int         SEQ_DEPTH = 33;
   // Fibonacci feedback bits for x^8+x^6+x^5+x^4+1 (register bits 7,5,4,3)
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   typedef logic [1:0] colour_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_ADD,
      S_SHOW_ON,
      S_SHOW_OFF,
      S_WAIT_IN,
      S_LOSE,
      S_WIN
   } seq_state_t;

endpackage

// File: rtl/colour_lfsr.sv
// 8-bit Fibonacci LFSR that supplies the pseudo-random colour for each new round.
// Advances only on step; reseeded only by the asynchronous reset.
module colour_lfsr
   import simon_pkg::*;
#(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic    clk,
   input  logic    reset,
   input  logic    step,
   output colour_t colour
);

   logic [7:0] r_lfsr;
   logic       w_fb;

   assign w_fb   = ^(r_lfsr & LFSR_TAPS);
   assign colour = r_lfsr[1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_lfsr <= SEED;
      end else if (step) begin
         r_lfsr <= {r_lfsr[6:0], w_fb};
      end
   end

endmodule

// File: rtl/simon_sequencer.sv
// Simon Says game controller: grows the stored sequence, plays it back with fixed
// on/off timing, then checks player presses (oldest colour first) to advance, lose or win.
module simon_sequencer
   import simon_pkg::*;
#(
   parameter int         MAX_LEN    = 33,
   parameter int         SHOW_TICKS = 25_000_000,
   parameter int         GAP_TICKS  = 12_500_000,
   parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              btn_valid,
   input  logic [1:0]        btn_colour,
   input  logic [32:0][1:0]  segment,
   output logic [1:0]        new_colour,
   output logic              load_colour,
   output logic              seg_clear,
   output logic              show_valid,
   output logic [1:0]        show_colour,
   output logic              input_ready,
   output logic [5:0]        level,
   output logic              game_over,
   output logic              win
);

   seq_state_t  r_state;
   seq_state_t  w_next;
   logic [5:0]  r_idx;
   logic [5:0]  r_level;
   logic [24:0] r_tick;
   colour_t     r_show_colour;
   colour_t     w_lfsr_colour;
   logic        w_lfsr_step;
   logic        w_tick_done;
   logic        w_idx_zero;
   logic        w_match;

   assign w_lfsr_step = (r_state == S_ADD);
   assign w_tick_done = (r_tick == 25'd0);
   assign w_idx_zero  = (r_idx == 6'd0);
   assign w_match     = (btn_colour == segment[r_idx]);

   colour_lfsr #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk    (clk),
      .reset  (reset),
      .step   (w_lfsr_step),
      .colour (w_lfsr_colour)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_LOSE, S_WIN: if (start) w_next = S_CLEAR;
         S_CLEAR:               w_next = S_ADD;
         S_ADD:                 w_next = S_SHOW_ON;
         S_SHOW_ON:             if (w_tick_done) w_next = S_SHOW_OFF;
         S_SHOW_OFF:            if (w_tick_done) w_next = w_idx_zero ? S_WAIT_IN : S_SHOW_ON;
         S_WAIT_IN: begin
            if (btn_valid) begin
               if (!w_match)                     w_next = S_LOSE;
               else if (w_idx_zero)              w_next = (r_level == 6'(MAX_LEN)) ? S_WIN : S_ADD;
            end
         end
         default:               w_next = S_IDLE;
      endcase
   end

   // The playback colour is registered on entry to SHOW_ON. On the ADD edge the
   // store is shifting in the new colour, so the post-shift entry [level] is
   // taken from pre-shift [level-1], or from the LFSR when the store was empty.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_level       <= 6'd0;
         r_idx         <= 6'd0;
         r_tick        <= 25'd0;
         r_show_colour <= 2'b00;
      end else begin
         case (r_state)
            S_CLEAR: r_level <= 6'd0;
            S_ADD: begin
               r_level       <= r_level + 6'd1;
               r_idx         <= r_level;
               r_tick        <= 25'(SHOW_TICKS - 1);
               r_show_colour <= (r_level == 6'd0) ? w_lfsr_colour : segment[r_level - 6'd1];
            end
            S_SHOW_ON: begin
               r_tick <= w_tick_done ? 25'(GAP_TICKS - 1) : r_tick - 25'd1;
            end
            S_SHOW_OFF: begin
               if (!w_tick_done) begin
                  r_tick <= r_tick - 25'd1;
               end else if (w_idx_zero) begin
                  r_idx <= r_level - 6'd1;
               end else begin
                  r_idx         <= r_idx - 6'd1;
                  r_tick        <= 25'(SHOW_TICKS - 1);
                  r_show_colour <= segment[r_idx - 6'd1];
               end
            end
            S_WAIT_IN: begin
               if (btn_valid && w_match && !w_idx_zero) r_idx <= r_idx - 6'd1;
            end
            default: ;
         endcase
      end
   end

   assign seg_clear   = (r_state == S_CLEAR);
   assign load_colour = (r_state == S_ADD);
   assign new_colour  = (r_state == S_ADD) ? w_lfsr_colour : 2'b00;
   assign show_valid  = (r_state == S_SHOW_ON);
   assign show_colour = (r_state == S_SHOW_ON) ? r_show_colour : 2'b00;
   assign input_ready = (r_state == S_WAIT_IN);
   assign game_over   = (r_state == S_LOSE);
   assign win         = (r_state == S_WIN);
   assign level       = r_level;

endmodule

// File: tb/tb_simon_sequencer.sv
// Bench for simon_sequencer with a behavioural segments_array and an LFSR/sequence reference model.
module tb_simon_sequencer;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             btn_valid = 1'b0;
   logic [1:0]       btn_colour = 2'b00;
   logic [32:0][1:0] seg_mem;
   logic [1:0]       new_colour;
   logic             load_colour, seg_clear, show_valid, input_ready, game_over, win;
   logic [1:0]       show_colour;
   logic [5:0]       level;

   int errs = 0;
   int checks = 0;
   int loads = 0;

   logic [7:0] ref_lfsr;
   logic [1:0] exp_seq[$];
   logic [1:0] obs_col[$];
   int         obs_on[$];
   int         obs_off[$];
   int         obs_glitch;

   always #5 clk = ~clk;

   simon_sequencer #(
      .MAX_LEN    (3),
      .SHOW_TICKS (4),
      .GAP_TICKS  (2),
      .LFSR_SEED  (8'hA5)
   ) dut (
      .clk         (clk),
      .reset       (rst_n),
      .start       (start),
      .btn_valid   (btn_valid),
      .btn_colour  (btn_colour),
      .segment     (seg_mem),
      .new_colour  (new_colour),
      .load_colour (load_colour),
      .seg_clear   (seg_clear),
      .show_valid  (show_valid),
      .show_colour (show_colour),
      .input_ready (input_ready),
      .level       (level),
      .game_over   (game_over),
      .win         (win)
   );

   // segments_array model: newest colour at [0]
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           seg_mem <= '0;
      else if (seg_clear)   seg_mem <= '0;
      else if (load_colour) seg_mem <= {seg_mem[31:0], new_colour};
   end

   always @(posedge clk) if (load_colour) loads++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: colour is the low two bits, then one polynomial step x^8+x^6+x^5+x^4+1
   function automatic logic [1:0] ref_next_colour();
      logic [1:0] c;
      c = ref_lfsr % 4;
      ref_lfsr = (ref_lfsr * 2) % 256 + (ref_lfsr[7] ^ ref_lfsr[5] ^ ref_lfsr[4] ^ ref_lfsr[3]);
      return c;
   endfunction

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic press(input logic [1:0] c);
      btn_colour = c;
      btn_valid  = 1'b1;
      tick();
      btn_valid  = 1'b0;
   endtask

   // Records lit colours, on-run and dark-run lengths until input_ready (bounded).
   task automatic collect_playback(input bit inject, output bit got_ready);
      int  budget = 0;
      int  run = 0;
      bit  prev = 1'b0;
      obs_col.delete(); obs_on.delete(); obs_off.delete(); obs_glitch = 0;
      while (!input_ready && budget < 2000) begin
         if (show_valid) begin
            if (!prev) begin
               if (obs_col.size() > 0) obs_off.push_back(run);
               obs_col.push_back(show_colour);
               run = 0;
            end else if (show_colour !== obs_col[$]) begin
               obs_glitch++;
            end
            run++;
         end else begin
            if (prev) begin
               obs_on.push_back(run);
               run = 0;
            end
            if (obs_col.size() > 0) run++;
         end
         prev = show_valid;
         if (inject && budget == 2) begin
            btn_colour = 2'($urandom_range(0, 3));
            btn_valid  = 1'b1;
         end
         tick();
         btn_valid = 1'b0;
         budget++;
      end
      if (obs_col.size() > 0) obs_off.push_back(run);
      got_ready = input_ready;
   endtask

   task automatic test_reset();
      int strobes = 0;
      rst_n = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         strobes += int'(seg_clear) + int'(load_colour) + int'(show_valid) + int'(input_ready)
                  + int'(game_over) + int'(win) + int'(level != 0) + int'(new_colour != 0)
                  + int'(show_colour != 0);
      end
      checks++; if (strobes !== 0) begin errs++; $display("FAIL reset_strobes: got %0d want 0", strobes); end
      checks++; if (level !== 6'd0) begin errs++; $display("FAIL reset_level: got %0d want 0", level); end
      checks++; if ({input_ready, game_over, win, show_valid} !== 4'b0) begin
         errs++; $display("FAIL reset_flags: got %b want 0000", {input_ready, game_over, win, show_valid});
      end
      rst_n = 1'b1;
      ref_lfsr = 8'hA5;
      exp_seq.delete();
      tick();
   endtask

   task automatic test_first_round();
      bit rdy;
      logic [1:0] c;
      pulse_start();
      checks++; if (seg_clear !== 1'b1) begin errs++; $display("FAIL start_seg_clear: got %b want 1", seg_clear); end
      checks++; if (load_colour !== 1'b0) begin errs++; $display("FAIL clear_no_load: got %b want 0", load_colour); end
      tick();
      c = ref_next_colour();
      exp_seq.push_back(c);
      checks++; if (load_colour !== 1'b1 || seg_clear !== 1'b0) begin
         errs++; $display("FAIL add_strobes: got load=%b clr=%b want load=1 clr=0", load_colour, seg_clear);
      end
      checks++; if (new_colour !== 2'b01 || new_colour !== c) begin
         errs++; $display("FAIL first_colour: got %b want %b", new_colour, c);
      end
      tick();
      checks++; if (show_valid !== 1'b1 || level !== 6'd1) begin
         errs++; $display("FAIL first_show: got sv=%b level=%0d want sv=1 level=1", show_valid, level);
      end
      collect_playback(1'b0, rdy);
      checks++; if (!rdy) begin errs++; $display("FAIL r1_ready: got timeout want input_ready"); end
      checks++; if (obs_col.size() !== 1 || obs_col[0] !== exp_seq[0]) begin
         errs++; $display("FAIL r1_colours: got n=%0d c=%b want n=1 c=%b", obs_col.size(), obs_col[0], exp_seq[0]);
      end
      checks++; if (obs_on[0] !== 4 || obs_off[0] !== 2 || obs_glitch !== 0) begin
         errs++; $display("FAIL r1_timing: got on=%0d off=%0d glitch=%0d want 4/2/0", obs_on[0], obs_off[0], obs_glitch);
      end
   endtask

   task automatic test_advance_ignore();
      bit rdy;
      logic [1:0] c;
      press(exp_seq[0]);
      c = ref_next_colour();
      exp_seq.push_back(c);
      checks++; if (load_colour !== 1'b1 || new_colour !== c) begin
         errs++; $display("FAIL r2_add: got load=%b col=%b want load=1 col=%b", load_colour, new_colour, c);
      end
      tick();
      collect_playback(1'b1, rdy);
      checks++; if (!rdy || level !== 6'd2) begin
         errs++; $display("FAIL r2_level: got ready=%b level=%0d want 1/2", rdy, level);
      end
      checks++; if (obs_col.size() !== 2) begin
         errs++; $display("FAIL r2_count: got %0d want 2", obs_col.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            checks++; if (obs_col[i] !== exp_seq[i] || obs_on[i] !== 4 || obs_off[i] !== 2) begin
               errs++; $display("FAIL r2_step%0d: got c=%b on=%0d off=%0d want c=%b 4/2",
                                i, obs_col[i], obs_on[i], obs_off[i], exp_seq[i]);
            end
         end
      end
   endtask

   task automatic test_lose_restart();
      int base;
      logic [1:0] c;
      press(exp_seq[0] ^ 2'($urandom_range(1, 3)));
      checks++; if (game_over !== 1'b1 || level !== 6'd2 || input_ready !== 1'b0) begin
         errs++; $display("FAIL lose: got go=%b level=%0d rdy=%b want 1/2/0", game_over, level, input_ready);
      end
      base = loads;
      for (int i = 0; i < 4; i++) press(2'($urandom_range(0, 3)));
      tick();
      checks++; if (game_over !== 1'b1 || level !== 6'd2 || loads !== base) begin
         errs++; $display("FAIL lose_hold: got go=%b level=%0d loads=%0d want 1/2/%0d", game_over, level, loads, base);
      end
      pulse_start();
      checks++; if (seg_clear !== 1'b1 || game_over !== 1'b0) begin
         errs++; $display("FAIL restart_clear: got clr=%b go=%b want 1/0", seg_clear, game_over);
      end
      tick();
      exp_seq.delete();
      c = ref_next_colour();
      exp_seq.push_back(c);
      checks++; if (load_colour !== 1'b1 || new_colour !== c) begin
         errs++; $display("FAIL restart_colour: got load=%b col=%b want 1/%b (lfsr not reseeded)", load_colour, new_colour, c);
      end
      tick();
      checks++; if (level !== 6'd1) begin errs++; $display("FAIL restart_level: got %0d want 1", level); end
   endtask

   task automatic test_win();
      bit rdy;
      logic [1:0] c;
      int base;
      base = loads - 1;
      for (int r = 1; r <= 3; r++) begin
         collect_playback(1'b0, rdy);
         checks++; if (!rdy || obs_col.size() !== r || obs_col != exp_seq) begin
            errs++; $display("FAIL win_round%0d_playback: got ready=%b n=%0d want 1/%0d", r, rdy, obs_col.size(), r);
         end
         for (int i = 0; i < r; i++) begin
            for (int w = $urandom_range(0, 2); w > 0; w--) tick();
            press(exp_seq[i]);
         end
         if (r < 3) begin
            c = ref_next_colour();
            exp_seq.push_back(c);
            checks++; if (load_colour !== 1'b1 || new_colour !== c) begin
               errs++; $display("FAIL win_round%0d_add: got load=%b col=%b want 1/%b", r, load_colour, new_colour, c);
            end
            tick();
         end
      end
      tick();
      checks++; if (win !== 1'b1 || level !== 6'd3 || input_ready !== 1'b0 || game_over !== 1'b0) begin
         errs++; $display("FAIL win_state: got win=%b level=%0d rdy=%b go=%b want 1/3/0/0", win, level, input_ready, game_over);
      end
      checks++; if (loads - base !== 3) begin
         errs++; $display("FAIL win_loads: got %0d want 3", loads - base);
      end
   endtask

   task automatic test_reset_midshow();
      logic [1:0] c;
      pulse_start();
      tick();
      tick();
      tick();
      checks++; if (show_valid !== 1'b1) begin errs++; $display("FAIL midshow_lit: got %b want 1", show_valid); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (show_valid !== 1'b0 || level !== 6'd0) begin
         errs++; $display("FAIL async_reset: got sv=%b level=%0d want 0/0", show_valid, level);
      end
      tick();
      tick();
      rst_n = 1'b1;
      ref_lfsr = 8'hA5;
      exp_seq.delete();
      tick();
      tick();
      checks++; if ({seg_clear, load_colour, show_valid, input_ready} !== 4'b0) begin
         errs++; $display("FAIL post_reset_idle: got %b want 0000", {seg_clear, load_colour, show_valid, input_ready});
      end
      pulse_start();
      tick();
      c = ref_next_colour();
      checks++; if (load_colour !== 1'b1 || new_colour !== 2'b01 || new_colour !== c) begin
         errs++; $display("FAIL reseed_colour: got load=%b col=%b want 1/01", load_colour, new_colour);
      end
   endtask

   initial begin
      test_reset();
      test_first_round();
      test_advance_ignore();
      test_lose_restart();
      test_win();
      test_reset_midshow();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/simon_sequencer.md
# simon_sequencer

Game-sequencing controller for the Simon Says core. It owns the `segments_array` colour store: clears it, appends one pseudo-random colour per round, and plays the stored sequence back on the display outputs with fixed on/off timing. It then checks the player's button presses against the stored sequence, advancing, losing or winning. It sits between the button debouncers/LED driver and `segments_array`, and drives that block's `new_colour`, `load_colour` and reset.

## Interface
- `MAX_LEN`, 33: rounds to win; range 1..33, matching `segments_array` depth.
- `SHOW_TICKS`, 25_000_000: cycles a colour is lit during playback; must be ≥1.
- `GAP_TICKS`, 12_500_000: dark cycles after each lit colour; must be ≥1.
- `LFSR_SEED`, 8'hA5: LFSR reset value; must be nonzero.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins a game.
- `btn_valid`  in  1  one-cycle pulse per debounced player press.
- `btn_colour`  in  2  colour of the press; sampled with `btn_valid`.
- `segment`  in  [32:0][1:0]  stored sequence from `segments_array`; newest at [0], oldest at [level-1].
- `new_colour`  out  2  colour to append; top level wires it to `segments_array.new_colour`.
- `load_colour`  out  1  append strobe; top level wires it to `sigs.load_colour`.
- `seg_clear`  out  1  clear strobe; top level uses it to reset `segments_array`.
- `show_valid`  out  1  playback LED enable.
- `show_colour`  out  2  playback LED colour.
- `input_ready`  out  1  high while a press is accepted.
- `level`  out  6  current sequence length, 0..MAX_LEN.
- `game_over`  out  1  held high in LOSE.
- `win`  out  1  held high in WIN.

## Operation
- States: IDLE, CLEAR, ADD, SHOW_ON, SHOW_OFF, WAIT_IN, LOSE, WIN.
- IDLE, LOSE, WIN: `start` → CLEAR. In all other states `start` is ignored.
- CLEAR (1 cycle): `seg_clear`=1, `level`←0 → ADD.
- ADD (1 cycle): `load_colour`=1, `new_colour`=lfsr[1:0], `level`←level+1, LFSR steps once, idx←level (new level−1) → SHOW_ON.
- SHOW_ON: `show_valid`=1, `show_colour`=segment[idx] for SHOW_TICKS cycles → SHOW_OFF.
- SHOW_OFF (GAP_TICKS cycles):
  - idx≠0: idx−1 → SHOW_ON.
  - idx=0: idx←level−1 → WAIT_IN.
- WAIT_IN: `input_ready`=1. On `btn_valid`:
  - btn_colour≠segment[idx] → LOSE.
  - Match, idx≠0 → idx−1.
  - Match, idx=0, level=MAX_LEN → WIN.
  - Match, idx=0, level<MAX_LEN → ADD.
- `btn_valid` outside WAIT_IN is ignored and has no side effects.
- LOSE/WIN hold `level` and the segment contents until `start`.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. It is loaded only by `reset` and never reseeded by `start`.
- Tick counter: 25-bit down-counter, reloaded on every entry to SHOW_ON or SHOW_OFF.
- idx width is 6 bits. idx never underflows because the transitions above guard idx=0.

## Timing
- Reset values: state IDLE, lfsr=LFSR_SEED, idx=0, counter=0; every output 0.
- Reset is asynchronous, so outputs clear immediately, including mid-playback.
- All outputs are registered or decoded from registered state only; there are no input-to-output combinational paths.
- `start` at edge N: `seg_clear` high in cycle N+1, `load_colour` high in cycle N+2, first `show_valid` in cycle N+3.
- `segment` is read no earlier than one cycle after `load_colour`, so the newly appended colour is visible at playback.
- `btn_valid` in the same cycle as the WAIT_IN entry edge is not accepted. The press must arrive while `input_ready` is already 1.
- Last correct press at edge M: `load_colour` high in cycle M+1.

## Structure
- Shared package `simon_pkg`:
  - `colour_t` (logic [1:0]).
  - `seq_state_t` enum.
  - `SEQ_DEPTH`=33.
  - LFSR tap mask constant.
- Sub-module `colour_lfsr`: 8-bit LFSR with `step` enable and seed parameter, exposing `colour_t` output.
- The FSM, idx and tick counter stay in `simon_sequencer`.

## Test plan
All scenarios use SHOW_TICKS=4, GAP_TICKS=2, and a bench model of `segments_array`.
- Reset, no stimulus for 10 cycles → all outputs 0, no strobes.
- `start` → `seg_clear` for 1 cycle; `load_colour` with new_colour=2'b01 (0xA5[1:0]); level=1; show_valid high exactly 4 cycles with segment[0]; then 2 dark cycles; then input_ready=1.
- Correct press → level=2; playback order is segment[1], then segment[0], each 4 on / 2 off. `btn_valid` pulsed mid-playback changes nothing.
- In round 2, first press wrong → game_over=1, level stays 2, input_ready=0. Later presses are ignored. `start` → seg_clear, level returns to 1.
- MAX_LEN=3, all presses correct → win=1 after the third round; exactly 3 `load_colour` pulses total.
- Reset asserted during SHOW_ON → show_valid drops without waiting for an edge. After release, state is IDLE and lfsr is reseeded: the next game's first colour is again 2'b01.
